// File: rtl/rvfi_monitor_pkg.sv
// Shared types and constants for the RVFI retirement-stream checker.
package rvfi_monitor_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [1:0] IXL_RV32 = 2'b01;
  localparam logic [1:0] MODE_M   = 2'b11;

  typedef enum logic [3:0] {
    ERR_NONE       = 4'd0,
    ERR_ORDER      = 4'd1,
    ERR_PC         = 4'd2,
    ERR_X0         = 4'd3,
    ERR_RS1        = 4'd4,
    ERR_RS2        = 4'd5,
    ERR_MEM        = 4'd6,
    ERR_ISA        = 4'd7,
    ERR_AFTER_HALT = 4'd8
  } err_code_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERROR  = 2'd2
  } mon_state_e;

endpackage

// File: rtl/rvfi_shadow_rf.sv
// Shadow copy of x1..x31 with per-register valid bits; x0 reads as a known zero.
module rvfi_shadow_rf
  import rvfi_monitor_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  output logic            valid_a_o,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [4:0]      raddr_b_i,
  output logic            valid_b_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] data_q [31:1];
  logic [XLEN-1:0] data_d [31:1];
  logic [31:1]     valid_q;
  logic [31:1]     valid_d;

  // A write in the same cycle as a clear survives: the clear-cycle packet seeds the file.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) valid_d = '0;
    if (we_i && (waddr_i != 5'd0)) begin
      data_d[waddr_i]  = wdata_i;
      valid_d[waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  always_comb begin
    valid_a_o = 1'b1;
    rdata_a_o = '0;
    if (raddr_a_i != 5'd0) begin
      valid_a_o = valid_q[raddr_a_i];
      rdata_a_o = data_q[raddr_a_i];
    end
  end

  always_comb begin
    valid_b_o = 1'b1;
    rdata_b_o = '0;
    if (raddr_b_i != 5'd0) begin
      valid_b_o = valid_q[raddr_b_i];
      rdata_b_o = data_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/rvfi_monitor.sv
// Single-retire RVFI consistency checker; latches the first violation as a sticky error.
module rvfi_monitor
  import rvfi_monitor_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             rvfi_valid,
  input  logic [CNT_W-1:0] rvfi_order,
  input  logic [31:0]      rvfi_insn,
  input  logic             rvfi_trap,
  input  logic             rvfi_halt,
  input  logic             rvfi_intr,
  input  logic [1:0]       rvfi_mode,
  input  logic [1:0]       rvfi_ixl,
  input  logic [4:0]       rvfi_rs1_addr,
  input  logic [4:0]       rvfi_rs2_addr,
  input  logic [4:0]       rvfi_rd_addr,
  input  logic [XLEN-1:0]  rvfi_rs1_rdata,
  input  logic [XLEN-1:0]  rvfi_rs2_rdata,
  input  logic [XLEN-1:0]  rvfi_rd_wdata,
  input  logic [XLEN-1:0]  rvfi_pc_rdata,
  input  logic [XLEN-1:0]  rvfi_pc_wdata,
  input  logic [XLEN-1:0]  rvfi_mem_addr,
  input  logic [XLEN-1:0]  rvfi_mem_rdata,
  input  logic [XLEN-1:0]  rvfi_mem_wdata,
  input  logic [3:0]       rvfi_mem_rmask,
  input  logic [3:0]       rvfi_mem_wmask,
  output logic             err_o,
  output logic [3:0]       err_code_o,
  output logic [CNT_W-1:0] err_order_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic             halted_o
);

  mon_state_e       state_q, state_d;
  logic             err_q, err_d;
  err_code_e        err_code_q, err_code_d;
  logic [CNT_W-1:0] err_order_q, err_order_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] exp_order_q, exp_order_d;
  logic [XLEN-1:0]  exp_pc_q, exp_pc_d;
  logic             sync_q, sync_d;

  logic             sh_we, sh_clr;
  logic             rs1_valid, rs2_valid;
  logic [XLEN-1:0]  rs1_shadow, rs2_shadow;
  err_code_e        chk_code;

  logic unused_ok;
  assign unused_ok = ^{rvfi_insn, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata};

  rvfi_shadow_rf #(.XLEN(XLEN)) u_shadow (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (sh_clr),
    .we_i      (sh_we),
    .waddr_i   (rvfi_rd_addr),
    .wdata_i   (rvfi_rd_wdata),
    .raddr_a_i (rvfi_rs1_addr),
    .valid_a_o (rs1_valid),
    .rdata_a_o (rs1_shadow),
    .raddr_b_i (rvfi_rs2_addr),
    .valid_b_o (rs2_valid),
    .rdata_b_o (rs2_shadow)
  );

  // Lowest code wins when several checks fail on the same packet.
  always_comb begin
    chk_code = ERR_NONE;
    if (!sync_q && (rvfi_order != exp_order_q))
      chk_code = ERR_ORDER;
    else if (!sync_q && !rvfi_intr && (rvfi_pc_rdata != exp_pc_q))
      chk_code = ERR_PC;
    else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0))
      chk_code = ERR_X0;
    else if (rs1_valid && (rvfi_rs1_rdata != rs1_shadow))
      chk_code = ERR_RS1;
    else if (rs2_valid && (rvfi_rs2_rdata != rs2_shadow))
      chk_code = ERR_RS2;
    else if ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0))
      chk_code = ERR_MEM;
    else if ((rvfi_ixl != IXL_RV32) || (rvfi_mode != MODE_M))
      chk_code = ERR_ISA;
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_order_d = err_order_q;
    retired_d   = retired_q;
    halted_d    = halted_q;
    exp_order_d = exp_order_q;
    exp_pc_d    = exp_pc_q;
    sync_d      = sync_q;
    sh_we       = 1'b0;
    sh_clr      = 1'b0;

    if (clear_i) begin
      state_d     = ST_RUN;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
      err_order_d = '0;
      retired_d   = '0;
      halted_d    = 1'b0;
      sh_clr      = 1'b1;
      sync_d      = 1'b1;
      // A packet coincident with clear becomes the unchecked baseline.
      if (rvfi_valid) begin
        exp_order_d = rvfi_order + CNT_W'(1);
        exp_pc_d    = rvfi_pc_wdata;
        sync_d      = 1'b0;
        sh_we       = !rvfi_trap && (rvfi_rd_addr != 5'd0);
      end
    end else if (rvfi_valid) begin
      unique case (state_q)
        ST_RUN: begin
          if (chk_code != ERR_NONE) begin
            state_d     = ST_ERROR;
            err_d       = 1'b1;
            err_code_d  = chk_code;
            err_order_d = rvfi_order;
          end else begin
            exp_order_d = (sync_q ? rvfi_order : exp_order_q) + CNT_W'(1);
            exp_pc_d    = rvfi_pc_wdata;
            retired_d   = retired_q + CNT_W'(1);
            sync_d      = 1'b0;
            sh_we       = !rvfi_trap && (rvfi_rd_addr != 5'd0);
            if (rvfi_halt) begin
              state_d  = ST_HALTED;
              halted_d = 1'b1;
            end
          end
        end
        ST_HALTED: begin
          state_d     = ST_ERROR;
          err_d       = 1'b1;
          err_code_d  = ERR_AFTER_HALT;
          err_order_d = rvfi_order;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_order_q <= '0;
      retired_q   <= '0;
      halted_q    <= 1'b0;
      exp_order_q <= '0;
      exp_pc_q    <= RESET_PC;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_order_q <= err_order_d;
      retired_q   <= retired_d;
      halted_q    <= halted_d;
      exp_order_q <= exp_order_d;
      exp_pc_q    <= exp_pc_d;
      sync_q      <= sync_d;
    end
  end

  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign err_order_o   = err_order_q;
  assign retired_cnt_o = retired_q;
  assign halted_o      = halted_q;

endmodule
